// File: rtl/clock_set_ctrl.sv
// Mode/time-setting controller for the digital clock: debounces MODE/SET, steps the setting FSM,
// and emits INC/CLR pulses and blink blanks. Define AUTOREPEAT_EN to enable held-SET auto-repeat.
module clock_set_ctrl #(
   parameter int DEB_N   = 3,
   parameter int TMO_S   = 30,
   parameter int RPT_DLY = 50,
   parameter int RPT_PER = 10
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       SEC_TICK,
   input  logic       SMP_TICK,
   input  logic       BTN_MODE,
   input  logic       BTN_SET,
   output logic       SEC_EN,
   output logic       SEC_CLR,
   output logic       MIN_INC,
   output logic       HR_INC,
   output logic       BLANK_HR,
   output logic       BLANK_MIN,
   output logic [1:0] MODE_Q
);

   typedef enum logic [1:0] {
      NORMAL  = 2'd0,
      SET_HR  = 2'd1,
      SET_MIN = 2'd2,
      SET_SEC = 2'd3
   } state_t;

   if (DEB_N < 1 || DEB_N > 15 || TMO_S < 1 || TMO_S > 63 ||
       RPT_PER < 1 || RPT_DLY < RPT_PER || RPT_DLY > 255) begin : g_param_check
      $error("clock_set_ctrl: parameter out of range");
   end

   state_t          state, state_nxt;
   logic [1:0]      sync_a, sync_b;      // bit 0 = MODE, bit 1 = SET
   logic [1:0][3:0] deb_cnt;
   logic [1:0]      level, level_d;
   logic            pm, ps, rpt_fire;
   logic [5:0]      tmo;
   logic            phase;
   logic            hr_nxt, min_nxt, clr_nxt;

   always_ff @(posedge CLK) begin
      if (RST) begin
         sync_a  <= '0;
         sync_b  <= '0;
         deb_cnt <= '0;
         level   <= '0;
         level_d <= '0;
      end else begin
         sync_a  <= {BTN_SET, BTN_MODE};
         sync_b  <= sync_a;
         level_d <= level;
         for (int i = 0; i < 2; i++) begin
            if (SMP_TICK) begin
               if (sync_b[i] != level[i]) begin
                  if (deb_cnt[i] == 4'(DEB_N - 1)) begin
                     level[i]   <= ~level[i];
                     deb_cnt[i] <= '0;
                  end else begin
                     deb_cnt[i] <= deb_cnt[i] + 4'd1;
                  end
               end else begin
                  deb_cnt[i] <= '0;
               end
            end
         end
      end
   end

   assign pm = level[0] & ~level_d[0];
   assign ps = level[1] & ~level_d[1];

`ifdef AUTOREPEAT_EN
   logic [7:0] rpt_cnt;
   logic       rpt_active;

   assign rpt_active = level[1] && (state == SET_HR || state == SET_MIN);
   assign rpt_fire   = rpt_active && SMP_TICK && (rpt_cnt == 8'(RPT_DLY - 1));

   // After the first repeat, reload so the next fire lands RPT_PER ticks later.
   always_ff @(posedge CLK) begin
      if (RST || !rpt_active || state_nxt != state)
         rpt_cnt <= '0;
      else if (SMP_TICK)
         rpt_cnt <= rpt_fire ? 8'(RPT_DLY - RPT_PER) : rpt_cnt + 8'd1;
   end
`else
   assign rpt_fire = 1'b0;
`endif

   always_ff @(posedge CLK) begin
      if (RST) begin
         state   <= NORMAL;
         HR_INC  <= 1'b0;
         MIN_INC <= 1'b0;
         SEC_CLR <= 1'b0;
      end else begin
         state   <= state_nxt;
         HR_INC  <= hr_nxt;
         MIN_INC <= min_nxt;
         SEC_CLR <= clr_nxt;
      end
   end

   // pm has priority: a coincident ps is dropped.
   always_comb begin
      state_nxt = state;
      hr_nxt    = 1'b0;
      min_nxt   = 1'b0;
      clr_nxt   = 1'b0;
      if (pm) begin
         case (state)
            NORMAL:  state_nxt = SET_HR;
            SET_HR:  state_nxt = SET_MIN;
            SET_MIN: state_nxt = SET_SEC;
            default: state_nxt = NORMAL;
         endcase
      end else if (ps || rpt_fire) begin
         case (state)
            SET_HR:  hr_nxt  = 1'b1;
            SET_MIN: min_nxt = 1'b1;
            SET_SEC: clr_nxt = ps;
            default: ;
         endcase
      end else if (state != NORMAL && tmo == 6'(TMO_S)) begin
         state_nxt = NORMAL;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST || state == NORMAL || state_nxt != state) begin
         tmo   <= '0;
         phase <= 1'b0;
      end else begin
         if (pm || ps || rpt_fire)
            tmo <= '0;
         else if (SEC_TICK)
            tmo <= tmo + 6'd1;
         if (SEC_TICK)
            phase <= ~phase;
      end
   end

   assign SEC_EN    = SEC_TICK && (state == NORMAL);
   assign BLANK_HR  = (state == SET_HR) && phase;
   assign BLANK_MIN = (state == SET_MIN) && phase;
   assign MODE_Q    = state;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed testbench for clock_set_ctrl: reset, debounce, field setting, timeout, hold and mid-run reset.
module tb_clock_set_ctrl;

   localparam int DEB_N = 3;

   logic       CLK = 1'b0;
   logic       RST, SEC_TICK, SMP_TICK, BTN_MODE, BTN_SET;
   logic       SEC_EN, SEC_CLR, MIN_INC, HR_INC, BLANK_HR, BLANK_MIN;
   logic [1:0] MODE_Q;

   int errors = 0;
   int checks = 0;
   int n_hr = 0, n_min = 0, n_clr = 0, n_multi = 0;
   int b_hr, b_min, b_clr, b_multi;
   logic p_hr = 1'b0, p_min = 1'b0, p_clr = 1'b0;
   logic en_seen;

   clock_set_ctrl #(.DEB_N(DEB_N), .TMO_S(30), .RPT_DLY(50), .RPT_PER(10)) dut (
      .CLK(CLK), .RST(RST), .SEC_TICK(SEC_TICK), .SMP_TICK(SMP_TICK),
      .BTN_MODE(BTN_MODE), .BTN_SET(BTN_SET), .SEC_EN(SEC_EN), .SEC_CLR(SEC_CLR),
      .MIN_INC(MIN_INC), .HR_INC(HR_INC), .BLANK_HR(BLANK_HR), .BLANK_MIN(BLANK_MIN),
      .MODE_Q(MODE_Q)
   );

   always #5 CLK = ~CLK;

   // One clock: drive ticks, note SEC_EN before the edge, sample pulses 1 ns after it.
   task automatic cyc(input logic smp, input logic sec);
      SMP_TICK = smp;
      SEC_TICK = sec;
      #1 en_seen = SEC_EN;
      @(posedge CLK);
      #1;
      SMP_TICK = 1'b0;
      SEC_TICK = 1'b0;
      if ((HR_INC && p_hr) || (MIN_INC && p_min) || (SEC_CLR && p_clr)) n_multi++;
      n_hr  += int'(HR_INC);
      n_min += int'(MIN_INC);
      n_clr += int'(SEC_CLR);
      p_hr = HR_INC; p_min = MIN_INC; p_clr = SEC_CLR;
   endtask

   task automatic samples(input int n);
      repeat (n) begin cyc(1'b1, 1'b0); cyc(1'b0, 1'b0); end
   endtask

   task automatic press(input logic m, input logic s, input int extra);
      BTN_MODE = m; BTN_SET = s;
      repeat (3) cyc(1'b0, 1'b0);
      samples(DEB_N + extra);
      BTN_MODE = 1'b0; BTN_SET = 1'b0;
      repeat (3) cyc(1'b0, 1'b0);
      samples(DEB_N);
   endtask

   task automatic snap();
      b_hr = n_hr; b_min = n_min; b_clr = n_clr; b_multi = n_multi;
   endtask

   task automatic test_reset();
      RST = 1'b1; SEC_TICK = 1'b0; SMP_TICK = 1'b0; BTN_MODE = 1'b0; BTN_SET = 1'b0;
      repeat (3) cyc(1'b0, 1'b0);
      RST = 1'b0;
      cyc(1'b0, 1'b0);
      checks++;
      if ({MODE_Q, SEC_CLR, MIN_INC, HR_INC, BLANK_HR, BLANK_MIN} !== 7'b0) begin
         errors++;
         $display("FAIL reset_outputs: got mode=%0d clr=%b min=%b hr=%b bh=%b bm=%b, expected all 0",
                  MODE_Q, SEC_CLR, MIN_INC, HR_INC, BLANK_HR, BLANK_MIN);
      end
      for (int t = 0; t < 3; t++) begin
         repeat (9) cyc(1'b0, 1'b0);
         cyc(1'b0, 1'b1);
         checks++;
         if (en_seen !== 1'b1) begin
            errors++; $display("FAIL normal_sec_en: tick %0d got %b expected 1", t, en_seen);
         end
      end
      checks++;
      if (n_hr + n_min + n_clr !== 0) begin
         errors++; $display("FAIL normal_no_pulses: got %0d expected 0", n_hr + n_min + n_clr);
      end
   endtask

   task automatic test_debounce();
      snap();
      BTN_MODE = 1'b1;
      repeat (3) cyc(1'b0, 1'b0);
      samples(2);
      cyc(1'b1, 1'b0);   // third sample: debounced level rises, pm now high
      checks++;
      if (MODE_Q !== 2'd0) begin
         errors++; $display("FAIL mode_latency_pre: got %0d expected 0", MODE_Q);
      end
      cyc(1'b0, 1'b0);
      checks++;
      if (MODE_Q !== 2'd1) begin
         errors++; $display("FAIL mode_latency_post: got %0d expected 1", MODE_Q);
      end
      samples(2);
      BTN_MODE = 1'b0;
      repeat (3) cyc(1'b0, 1'b0);
      samples(DEB_N);
      checks++;
      if (MODE_Q !== 2'd1) begin
         errors++; $display("FAIL mode_once: got %0d expected 1", MODE_Q);
      end
      BTN_SET = 1'b1;
      repeat (3) cyc(1'b0, 1'b0);
      samples(2);
      BTN_SET = 1'b0;
      repeat (3) cyc(1'b0, 1'b0);
      samples(DEB_N);
      checks++;
      if (n_hr - b_hr !== 0) begin
         errors++; $display("FAIL glitch_hr_inc: got %0d pulses expected 0", n_hr - b_hr);
      end
   endtask

   task automatic test_set_min();
      press(1'b1, 1'b0, 0);
      checks++;
      if (MODE_Q !== 2'd2) begin
         errors++; $display("FAIL enter_set_min: got %0d expected 2", MODE_Q);
      end
      snap();
      repeat (4) press(1'b0, 1'b1, 0);
      checks++;
      if (n_min - b_min !== 4 || n_multi != b_multi || n_hr != b_hr || n_clr != b_clr) begin
         errors++;
         $display("FAIL min_inc_count: got min=%0d hr=%0d clr=%0d wide=%0d expected 4/0/0/0",
                  n_min - b_min, n_hr - b_hr, n_clr - b_clr, n_multi - b_multi);
      end
      checks++;
      if (BLANK_MIN !== 1'b0) begin
         errors++; $display("FAIL blank_min_init: got %b expected 0", BLANK_MIN);
      end
      cyc(1'b0, 1'b1);
      checks++;
      if (en_seen !== 1'b0 || BLANK_MIN !== 1'b1 || BLANK_HR !== 1'b0) begin
         errors++; $display("FAIL set_min_tick1: got en=%b bm=%b bh=%b expected 0/1/0", en_seen, BLANK_MIN, BLANK_HR);
      end
      cyc(1'b0, 1'b0);
      cyc(1'b0, 1'b1);
      checks++;
      if (en_seen !== 1'b0 || BLANK_MIN !== 1'b0) begin
         errors++; $display("FAIL set_min_tick2: got en=%b bm=%b expected 0/0", en_seen, BLANK_MIN);
      end
   endtask

   task automatic test_set_sec();
      press(1'b1, 1'b0, 0);
      checks++;
      if (MODE_Q !== 2'd3 || BLANK_MIN !== 1'b0) begin
         errors++; $display("FAIL enter_set_sec: got mode=%0d bm=%b expected 3/0", MODE_Q, BLANK_MIN);
      end
      snap();
      press(1'b0, 1'b1, 0);
      checks++;
      if (n_clr - b_clr !== 1 || n_multi != b_multi || n_min != b_min) begin
         errors++; $display("FAIL sec_clr_pulse: got clr=%0d wide=%0d min=%0d expected 1/0/0",
                            n_clr - b_clr, n_multi - b_multi, n_min - b_min);
      end
      press(1'b1, 1'b0, 0);
      cyc(1'b0, 1'b1);
      checks++;
      if (MODE_Q !== 2'd0 || en_seen !== 1'b1) begin
         errors++; $display("FAIL resume_normal: got mode=%0d en=%b expected 0/1", MODE_Q, en_seen);
      end
   endtask

   task automatic test_timeout();
      press(1'b1, 1'b0, 0);
      cyc(1'b0, 1'b1);
      checks++;
      if (MODE_Q !== 2'd1 || BLANK_HR !== 1'b1) begin
         errors++; $display("FAIL set_hr_blink: got mode=%0d bh=%b expected 1/1", MODE_Q, BLANK_HR);
      end
      for (int t = 2; t <= 30; t++) begin
         cyc(1'b0, 1'b0);
         cyc(1'b0, 1'b1);
      end
      checks++;
      if (MODE_Q !== 2'd1) begin
         errors++; $display("FAIL timeout_early: got %0d expected 1 at 30th tick edge", MODE_Q);
      end
      cyc(1'b0, 1'b0);
      checks++;
      if (MODE_Q !== 2'd0 || BLANK_HR !== 1'b0) begin
         errors++; $display("FAIL timeout_return: got mode=%0d bh=%b expected 0/0", MODE_Q, BLANK_HR);
      end
   endtask

   task automatic test_hold();
      int exp_hr;
`ifdef AUTOREPEAT_EN
      exp_hr = 5;
`else
      exp_hr = 1;
`endif
      press(1'b1, 1'b0, 0);
      snap();
      press(1'b0, 1'b1, 80);
      checks++;
      if (n_hr - b_hr !== exp_hr || n_multi != b_multi) begin
         errors++; $display("FAIL hold_hr_inc: got %0d pulses (wide=%0d) expected %0d",
                            n_hr - b_hr, n_multi - b_multi, exp_hr);
      end
   endtask

   task automatic test_simultaneous();
      snap();
      press(1'b1, 1'b1, 0);
      checks++;
      if (MODE_Q !== 2'd2 || n_hr != b_hr || n_min != b_min) begin
         errors++; $display("FAIL pm_wins: got mode=%0d hr=%0d min=%0d expected 2/0/0",
                            MODE_Q, n_hr - b_hr, n_min - b_min);
      end
   endtask

   task automatic test_reset_mid();
      press(1'b1, 1'b0, 0);
      press(1'b1, 1'b0, 0);
      press(1'b1, 1'b0, 0);   // SET_MIN -> SET_SEC -> NORMAL -> SET_HR
      checks++;
      if (MODE_Q !== 2'd1) begin
         errors++; $display("FAIL wrap_to_set_hr: got %0d expected 1", MODE_Q);
      end
      snap();
      BTN_SET = 1'b1;
      repeat (3) cyc(1'b0, 1'b0);
      samples(2);
      cyc(1'b1, 1'b0);        // ps is high now; reset must swallow the pulse
      RST = 1'b1;
      BTN_SET = 1'b0;
      cyc(1'b0, 1'b0);
      RST = 1'b0;
      checks++;
      if (MODE_Q !== 2'd0 || HR_INC !== 1'b0 || BLANK_HR !== 1'b0) begin
         errors++; $display("FAIL reset_mid: got mode=%0d hr=%b bh=%b expected 0/0/0", MODE_Q, HR_INC, BLANK_HR);
      end
      repeat (4) cyc(1'b0, 1'b0);
      samples(DEB_N);
      checks++;
      if (n_hr - b_hr !== 0 || MODE_Q !== 2'd0) begin
         errors++; $display("FAIL reset_drop_pulse: got hr=%0d mode=%0d expected 0/0", n_hr - b_hr, MODE_Q);
      end
   endtask

   initial begin
      test_reset();
      test_debounce();
      test_set_min();
      test_set_sec();
      test_timeout();
      test_hold();
      test_simultaneous();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
